mult_div_unit: RTL and testbench

//  E-stage multiply/divide unit owning the HI/LO registers; the producer of the E_start/E_busy pair

---
 rtl/mult_div_unit.sv | 138 +++++++++++++
 tb/tb_mult_div_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit owning HI/LO, fixed-latency busy model.
// Optional madd/maddu/msub/msubu ops (9-12) enabled by defining MDU_MADD_EN.
// Ports: clk, reset (sync, active-high), E_start, E_mdu_op[3:0], E_A[31:0], E_B[31:0],
//        E_busy (registered), E_mdu_out[31:0] (mfhi/mflo read), HI_o/LO_o[31:0] (trace).
module mult_div_unit #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [3:0]  E_mdu_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        E_busy,
  output logic [31:0] E_mdu_out,
  output logic [31:0] HI_o,
  output logic [31:0] LO_o
);

  localparam int MAXL = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [63:0]     r_pend, w_pend_nx;
  logic [31:0]     r_hi, r_lo, w_hi_nx, w_lo_nx;

  logic [63:0]     w_sext_a, w_sext_b, w_prod_s, w_prod_u;
  logic [31:0]     w_abs_a, w_abs_b, w_q, w_r, w_sq, w_sr;
  logic [31:0]     w_uq, w_ur;
  logic [63:0]     w_res;
  logic [CW-1:0]   w_lat;
  logic            w_cls;

  assign w_sext_a = {{32{E_A[31]}}, E_A};
  assign w_sext_b = {{32{E_B[31]}}, E_B};
  assign w_prod_s = w_sext_a * w_sext_b;
  assign w_prod_u = {32'd0, E_A} * {32'd0, E_B};

  // Signed divide through magnitudes; this also yields the
  // 0x80000000 / -1 case (LO=0x80000000, HI=0) without special casing.
  assign w_abs_a = E_A[31] ? -E_A : E_A;
  assign w_abs_b = E_B[31] ? -E_B : E_B;
  assign w_q     = w_abs_a / w_abs_b;
  assign w_r     = w_abs_a % w_abs_b;
  assign w_sq    = (E_A[31] ^ E_B[31]) ? -w_q : w_q;
  assign w_sr    = E_A[31] ? -w_r : w_r;
  assign w_uq    = E_A / E_B;
  assign w_ur    = E_A % E_B;

`ifdef MDU_MADD_EN
  logic [63:0] w_acc;
  assign w_acc = {r_hi, r_lo};
`endif

  always_comb begin
    w_res = {r_hi, r_lo};
    w_lat = CW'(MULT_LAT);
    w_cls = 1'b0;
    case (E_mdu_op)
      4'd1: begin w_res = w_prod_s; w_cls = 1'b1; end
      4'd2: begin w_res = w_prod_u; w_cls = 1'b1; end
      4'd3: begin
        // Divide by zero completes with HI/LO unchanged.
        if (E_B != 32'd0) w_res = {w_sr, w_sq};
        w_lat = CW'(DIV_LAT);
        w_cls = 1'b1;
      end
      4'd4: begin
        if (E_B != 32'd0) w_res = {w_ur, w_uq};
        w_lat = CW'(DIV_LAT);
        w_cls = 1'b1;
      end
`ifdef MDU_MADD_EN
      4'd9:  begin w_res = w_acc + w_prod_s; w_cls = 1'b1; end
      4'd10: begin w_res = w_acc + w_prod_u; w_cls = 1'b1; end
      4'd11: begin w_res = w_acc - w_prod_s; w_cls = 1'b1; end
      4'd12: begin w_res = w_acc - w_prod_u; w_cls = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_pend_nx  = r_pend;
    w_hi_nx    = r_hi;
    w_lo_nx    = r_lo;
    unique case (r_state)
      S_IDLE: begin
        if (E_start && w_cls) begin
          w_state_nx = S_BUSY;
          w_cnt_nx   = w_lat;
          w_pend_nx  = w_res;
        end else begin
          if (E_mdu_op == 4'd5) w_hi_nx = E_A;
          if (E_mdu_op == 4'd6) w_lo_nx = E_A;
        end
      end
      S_BUSY: begin
        // Starts and mthi/mtlo seen here are dropped.
        w_cnt_nx = r_cnt - 1'b1;
        if (r_cnt <= CW'(1)) begin
          w_cnt_nx   = '0;
          w_state_nx = S_IDLE;
          {w_hi_nx, w_lo_nx} = r_pend;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_pend  <= w_pend_nx;
      r_hi    <= w_hi_nx;
      r_lo    <= w_lo_nx;
    end
  end

  assign E_busy    = (r_state == S_BUSY);
  assign E_mdu_out = (E_mdu_op == 4'd7) ? r_hi :
                     (E_mdu_op == 4'd8) ? r_lo : 32'd0;
  assign HI_o      = r_hi;
  assign LO_o      = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed checks of mult_div_unit
// against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;

  localparam int ML = 5;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_start;
  logic [3:0]  E_mdu_op;
  logic [31:0] E_A, E_B;
  logic        E_busy;
  logic [31:0] E_mdu_out, HI_o, LO_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi = 0, m_lo = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .E_start(E_start),
    .E_mdu_op(E_mdu_op), .E_A(E_A), .E_B(E_B),
    .E_busy(E_busy), .E_mdu_out(E_mdu_out),
    .HI_o(HI_o), .LO_o(LO_o)
  );

  function automatic logic [63:0] ref_res(input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] hi, input logic [31:0] lo);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] acc;
    sa = $signed(a); sb = $signed(b);
    ua = a; ub = b;
    acc = {hi, lo};
    case (op)
      4'd1: return 64'(sa * sb);
      4'd2: return 64'(ua * ub);
      4'd3: begin
        if (b == 0) return acc;
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 0) return acc;
        return {32'(ua % ub), 32'(ua / ub)};
      end
      4'd9:  return acc + 64'(sa * sb);
      4'd10: return acc + 64'(ua * ub);
      4'd11: return acc - 64'(sa * sb);
      4'd12: return acc - 64'(ua * ub);
      default: return acc;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
    return (op == 4'd3 || op == 4'd4) ? DL : ML;
  endfunction

  task automatic start_op(input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    E_start = 1'b1; E_mdu_op = op; E_A = a; E_B = b;
    @(negedge clk);
    E_start = 1'b0; E_mdu_op = 4'd0; E_A = 0; E_B = 0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (E_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic write_hilo(input logic [31:0] hi, input logic [31:0] lo);
    @(negedge clk); E_mdu_op = 4'd5; E_A = hi;
    @(negedge clk); E_mdu_op = 4'd6; E_A = lo;
    @(negedge clk); E_mdu_op = 4'd0; E_A = 0;
    m_hi = hi; m_lo = lo;
  endtask

  task automatic test_reset();
    reset = 1'b1; E_start = 0; E_mdu_op = 4'd7; E_A = 0; E_B = 0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (E_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", E_busy); end
    n_checks++; if ({HI_o, LO_o} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo: got %h want 0", {HI_o, LO_o}); end
    n_checks++; if (E_mdu_out !== 32'd0) begin n_fail++; $display("FAIL reset_mfhi: got %h want 0", E_mdu_out); end
    reset = 1'b0; E_mdu_op = 4'd0;
    m_hi = 0; m_lo = 0;
  endtask

  task automatic test_mult();
    int n;
    logic [3:0] op;
    logic [31:0] a, b;
    logic [63:0] exp;
    start_op(4'd1, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    n_checks++; if (n !== ML) begin n_fail++; $display("FAIL mult_lat: got %0d want %0d", n, ML); end
    n_checks++; if ({HI_o, LO_o} !== 64'hFFFFFFFF_FFFFFFFA) begin n_fail++; $display("FAIL mult_dir: got %h want FFFFFFFFFFFFFFFA", {HI_o, LO_o}); end
    start_op(4'd2, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    n_checks++; if ({HI_o, LO_o} !== 64'h00000002_FFFFFFFA) begin n_fail++; $display("FAIL multu_dir: got %h want 00000002FFFFFFFA", {HI_o, LO_o}); end
    m_hi = HI_o; m_lo = LO_o;
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(1, 2));
      a = $urandom; b = $urandom;
      exp = ref_res(op, a, b, m_hi, m_lo);
      start_op(op, a, b);
      wait_idle(n);
      n_checks++; if (n !== ML) begin n_fail++; $display("FAIL mult_rnd_lat: op %0d got %0d want %0d", op, n, ML); end
      n_checks++; if ({HI_o, LO_o} !== exp) begin n_fail++; $display("FAIL mult_rnd: op %0d a %h b %h got %h want %h", op, a, b, {HI_o, LO_o}, exp); end
      {m_hi, m_lo} = exp;
    end
  endtask

  task automatic test_div();
    int n;
    logic [3:0] op;
    logic [31:0] a, b;
    logic [63:0] exp;
    start_op(4'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    n_checks++; if (n !== DL) begin n_fail++; $display("FAIL div_lat: got %0d want %0d", n, DL); end
    n_checks++; if ({HI_o, LO_o} !== 64'hFFFFFFFF_FFFFFFFD) begin n_fail++; $display("FAIL div_dir: got %h want FFFFFFFFFFFFFFFD", {HI_o, LO_o}); end
    start_op(4'd4, 32'd7, 32'd0);
    wait_idle(n);
    n_checks++; if (n !== DL) begin n_fail++; $display("FAIL divz_lat: got %0d want %0d", n, DL); end
    n_checks++; if ({HI_o, LO_o} !== 64'hFFFFFFFF_FFFFFFFD) begin n_fail++; $display("FAIL divz_keep: got %h want FFFFFFFFFFFFFFFD", {HI_o, LO_o}); end
    start_op(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    n_checks++; if ({HI_o, LO_o} !== 64'h00000000_80000000) begin n_fail++; $display("FAIL div_ovf: got %h want 0000000080000000", {HI_o, LO_o}); end
    m_hi = 32'd0; m_lo = 32'h80000000;
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(3, 4));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      exp = ref_res(op, a, b, m_hi, m_lo);
      start_op(op, a, b);
      wait_idle(n);
      n_checks++; if (n !== DL) begin n_fail++; $display("FAIL div_rnd_lat: op %0d got %0d want %0d", op, n, DL); end
      n_checks++; if ({HI_o, LO_o} !== exp) begin n_fail++; $display("FAIL div_rnd: op %0d a %h b %h got %h want %h", op, a, b, {HI_o, LO_o}, exp); end
      {m_hi, m_lo} = exp;
    end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk); E_mdu_op = 4'd5; E_A = 32'h12345678;
    @(negedge clk); E_mdu_op = 4'd7; E_A = 0; #1;
    n_checks++; if (E_mdu_out !== 32'h12345678) begin n_fail++; $display("FAIL mfhi: got %h want 12345678", E_mdu_out); end
    @(negedge clk); E_mdu_op = 4'd6; E_A = 32'h9ABCDEF0;
    @(negedge clk); E_mdu_op = 4'd8; E_A = 0; #1;
    n_checks++; if (E_mdu_out !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL mflo: got %h want 9abcdef0", E_mdu_out); end
    n_checks++; if (HI_o !== 32'h12345678) begin n_fail++; $display("FAIL mtlo_hi_keep: got %h want 12345678", HI_o); end
    @(negedge clk); E_mdu_op = 4'd0; #1;
    n_checks++; if (E_mdu_out !== 32'd0) begin n_fail++; $display("FAIL mdu_out_none: got %h want 0", E_mdu_out); end
    m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk); E_start = 1; E_mdu_op = 4'd3; E_A = 32'd100; E_B = 32'd7;
    @(negedge clk); n = 0; if (E_busy) n++;
    E_start = 1; E_mdu_op = 4'd1; E_A = 32'd5; E_B = 32'd6;
    @(negedge clk); if (E_busy) n++;
    E_start = 0; E_mdu_op = 4'd5; E_A = 32'hDEADBEEF;
    @(negedge clk); if (E_busy) n++;
    E_mdu_op = 4'd0; E_A = 0; E_B = 0;
    @(negedge clk);
    while (E_busy && n < 200) begin n++; @(negedge clk); end
    n_checks++; if (n !== DL) begin n_fail++; $display("FAIL b2b_lat: got %0d want %0d", n, DL); end
    n_checks++; if ({HI_o, LO_o} !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL b2b_res: got %h want %h", {HI_o, LO_o}, {32'd2, 32'd14}); end
    @(negedge clk);
    n_checks++; if (E_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_rebusy: got %b want 0", E_busy); end
    m_hi = 32'd2; m_lo = 32'd14;
  endtask

  task automatic test_reset_mid_div();
    write_hilo(32'hAAAA0000, 32'h00005555);
    start_op(4'd3, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (E_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", E_busy); end
    n_checks++; if ({HI_o, LO_o} !== 64'd0) begin n_fail++; $display("FAIL rstmid_hilo: got %h want 0", {HI_o, LO_o}); end
    reset = 1'b0;
    repeat (15) @(negedge clk);
    n_checks++; if ({E_busy, HI_o, LO_o} !== 65'd0) begin n_fail++; $display("FAIL rstmid_late: got %h want 0", {E_busy, HI_o, LO_o}); end
    m_hi = 0; m_lo = 0;
  endtask

  task automatic test_invalid_op();
    logic [3:0] op;
    logic [31:0] exp_out;
    write_hilo(32'h0BADF00D, 32'hCAFEBABE);
    for (int k = 0; k < 16; k++) begin
      op = 4'(k);
      if (op >= 4'd1 && op <= 4'd6) continue;
`ifdef MDU_MADD_EN
      if (op >= 4'd9 && op <= 4'd12) continue;
`endif
      @(negedge clk); E_start = 1; E_mdu_op = op; E_A = $urandom; E_B = $urandom; #1;
      exp_out = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
      n_checks++; if (E_mdu_out !== exp_out) begin n_fail++; $display("FAIL inv_out: op %0d got %h want %h", op, E_mdu_out, exp_out); end
      @(negedge clk); E_start = 0; E_mdu_op = 4'd0;
      n_checks++; if (E_busy !== 1'b0) begin n_fail++; $display("FAIL inv_busy: op %0d got %b want 0", op, E_busy); end
      n_checks++; if ({HI_o, LO_o} !== {m_hi, m_lo}) begin n_fail++; $display("FAIL inv_hilo: op %0d got %h want %h", op, {HI_o, LO_o}, {m_hi, m_lo}); end
    end
  endtask

`ifdef MDU_MADD_EN
  task automatic test_madd();
    int n;
    logic [3:0] op;
    logic [31:0] a, b;
    logic [63:0] exp;
    write_hilo(32'd0, 32'hFFFFFFFF);
    start_op(4'd9, 32'd1, 32'd1);
    wait_idle(n);
    n_checks++; if (n !== ML) begin n_fail++; $display("FAIL madd_lat: got %0d want %0d", n, ML); end
    n_checks++; if ({HI_o, LO_o} !== 64'h00000001_00000000) begin n_fail++; $display("FAIL madd_dir: got %h want 0000000100000000", {HI_o, LO_o}); end
    start_op(4'd12, 32'd1, 32'd1);
    wait_idle(n);
    n_checks++; if ({HI_o, LO_o} !== 64'h00000000_FFFFFFFF) begin n_fail++; $display("FAIL msubu_dir: got %h want 00000000FFFFFFFF", {HI_o, LO_o}); end
    m_hi = 0; m_lo = 32'hFFFFFFFF;
    for (int i = 0; i < 6; i++) begin
      op = 4'($urandom_range(9, 12));
      a = $urandom; b = $urandom;
      exp = ref_res(op, a, b, m_hi, m_lo);
      start_op(op, a, b);
      wait_idle(n);
      n_checks++; if ({n, HI_o, LO_o} !== {ML, exp}) begin n_fail++; $display("FAIL madd_rnd: op %0d lat %0d got %h want %h", op, n, {HI_o, LO_o}, exp); end
      {m_hi, m_lo} = exp;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_back_to_back();
    test_reset_mid_div();
    test_invalid_op();
`ifdef MDU_MADD_EN
    test_madd();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
